// File: rtl/hdu_ctrl.sv
// ============================================================================
// Module   : hdu_ctrl
// Brief    : Hazard detect unit for the 5-stage core. Detects load-use
//            hazards and inserts LOAD_BUBBLES bubbles. Handles branch
//            flush, mul/div occupancy of EX and LSU back-pressure. Drives
//            per-stage stall/flush controls, combinationally from state and
//            the current inputs.
// Optional : `define HDU_PERF_CNT_EN adds the perf_stall_cnt and
//            perf_flush_cnt cycle counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hdu_ctrl #(
  parameter int REG_AW       = 5,
  parameter int LOAD_BUBBLES = 1,
  parameter int CNT_W        = 4,
  parameter int PERF_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_rs1_read,
  input  logic              id_rs2_read,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              ex_mem_read,
  input  logic              take_branch,
  input  logic              muldiv_start,
  input  logic              muldiv_done,
  input  logic              mem_busy,
  output logic              if_flush,
  output logic              id_flush,
  output logic              ex_flush,
  output logic              if_stall,
  output logic              id_stall,
  output logic              ex_stall,
  output logic              mem_stall,
  output logic              load_dep
`ifdef HDU_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

  // State encoding
  localparam logic [1:0] c_st_run       = 2'd0;
  localparam logic [1:0] c_st_load_wait = 2'd1;
  localparam logic [1:0] c_st_md_busy   = 2'd2;

  // Counter value loaded on entry to LOAD_WAIT: the detecting cycle already
  // produced the first bubble, so LOAD_BUBBLES-1 remain.
  localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(LOAD_BUBBLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_zero = '0;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_load_dep;

  // Raw load-use detection: EX load writing a register the ID instruction reads
  always_comb begin
    w_load_dep = ex_mem_read && (ex_rd_addr != '0) &&
                 ((id_rs1_read && (id_rs1_addr == ex_rd_addr)) ||
                  (id_rs2_read && (id_rs2_addr == ex_rd_addr)));
  end

  // Next-state and stall/flush decode, priority rst > mem_busy > branch > muldiv > load_dep
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    ex_flush  = 1'b0;
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    ex_stall  = 1'b0;
    mem_stall = 1'b0;
    load_dep  = 1'b0;

    if (rst) begin
      state_d = c_st_run;
      cnt_d   = c_cnt_zero;
    end else begin
      load_dep = w_load_dep;
      if (mem_busy) begin
        // Whole pipe holds; a pending branch stays in EX and is seen later
        if_stall  = 1'b1;
        id_stall  = 1'b1;
        ex_stall  = 1'b1;
        mem_stall = 1'b1;
      end else begin
        case (state_q)
          c_st_run: begin
            if (take_branch) begin
              if_flush = 1'b1;
              id_flush = 1'b1;
            end else if (muldiv_start) begin
              // A single-cycle completion needs no hold at all
              if (!muldiv_done) begin
                if_stall = 1'b1;
                id_stall = 1'b1;
                ex_stall = 1'b1;
                ex_flush = 1'b1;
                state_d  = c_st_md_busy;
              end
            end else if (w_load_dep) begin
              if_stall = 1'b1;
              id_stall = 1'b1;
              id_flush = 1'b1;
              if (LOAD_BUBBLES > 1) begin
                state_d = c_st_load_wait;
                cnt_d   = c_cnt_init;
              end
            end
          end

          c_st_load_wait: begin
            if (take_branch) begin
              if_flush = 1'b1;
              id_flush = 1'b1;
              state_d  = c_st_run;
              cnt_d    = c_cnt_zero;
            end else begin
              if_stall = 1'b1;
              id_stall = 1'b1;
              id_flush = 1'b1;
              cnt_d    = cnt_q - c_cnt_one;
              if (cnt_q == c_cnt_one) begin
                state_d = c_st_run;
              end
            end
          end

          c_st_md_busy: begin
            // EX holds the mul/div op, so branch and load hazards cannot be live here
            if (muldiv_done) begin
              state_d = c_st_run;
            end else begin
              if_stall = 1'b1;
              id_stall = 1'b1;
              ex_stall = 1'b1;
              ex_flush = 1'b1;
            end
          end

          default: begin
            state_d = c_st_run;
            cnt_d   = c_cnt_zero;
          end
        endcase
      end
    end
  end

  // State and bubble counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_st_run;
      cnt_q   <= c_cnt_zero;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HDU_PERF_CNT_EN
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
  logic [PERF_W-1:0] perf_flush_q, perf_flush_d;

  // Count IF stall / IF flush cycles, wrapping naturally at 2^PERF_W
  always_comb begin
    perf_stall_d = perf_stall_q + PERF_W'(if_stall);
    perf_flush_d = perf_flush_q + PERF_W'(if_flush);
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hdu_ctrl.sv
// ============================================================================
// Module   : tb_hdu_ctrl
// Brief    : Self-checking bench for hdu_ctrl. Two instances (LOAD_BUBBLES=1
//            and 3) share the stimulus; a behavioural model tracking
//            "mul/div in flight" and "bubbles still owed" predicts outputs.
//            Optional HDU_PERF_CNT_EN counters are checked when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hdu_ctrl;

  localparam int AW = 5;
  localparam int LB [2] = '{1, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic          id_rs1_read, id_rs2_read, ex_mem_read;
  logic          take_branch, muldiv_start, muldiv_done, mem_busy;

  // {if_flush, id_flush, ex_flush, if_stall, id_stall, ex_stall, mem_stall, load_dep}
  wire [7:0] obs_lb1, obs_lb3;
`ifdef HDU_PERF_CNT_EN
  wire [31:0] ps_lb1, pf_lb1, ps_lb3, pf_lb3;
`endif

  hdu_ctrl #(.REG_AW(AW), .LOAD_BUBBLES(1), .CNT_W(4), .PERF_W(32)) u_dut_lb1 (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_read(id_rs1_read), .id_rs2_read(id_rs2_read),
    .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
    .take_branch(take_branch), .muldiv_start(muldiv_start),
    .muldiv_done(muldiv_done), .mem_busy(mem_busy),
    .if_flush(obs_lb1[7]), .id_flush(obs_lb1[6]), .ex_flush(obs_lb1[5]),
    .if_stall(obs_lb1[4]), .id_stall(obs_lb1[3]), .ex_stall(obs_lb1[2]),
    .mem_stall(obs_lb1[1]), .load_dep(obs_lb1[0])
`ifdef HDU_PERF_CNT_EN
    , .perf_stall_cnt(ps_lb1), .perf_flush_cnt(pf_lb1)
`endif
  );

  hdu_ctrl #(.REG_AW(AW), .LOAD_BUBBLES(3), .CNT_W(4), .PERF_W(32)) u_dut_lb3 (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_read(id_rs1_read), .id_rs2_read(id_rs2_read),
    .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
    .take_branch(take_branch), .muldiv_start(muldiv_start),
    .muldiv_done(muldiv_done), .mem_busy(mem_busy),
    .if_flush(obs_lb3[7]), .id_flush(obs_lb3[6]), .ex_flush(obs_lb3[5]),
    .if_stall(obs_lb3[4]), .id_stall(obs_lb3[3]), .ex_stall(obs_lb3[2]),
    .mem_stall(obs_lb3[1]), .load_dep(obs_lb3[0])
`ifdef HDU_PERF_CNT_EN
    , .perf_stall_cnt(ps_lb3), .perf_flush_cnt(pf_lb3)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, one slot per instance
  bit          md_busy [2];
  int          owed    [2];
  logic [31:0] m_pstall [2];
  logic [31:0] m_pflush [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs and next model state from the current inputs
  task automatic predict(input int k, output logic [7:0] e, output bit md_n, output int owed_n);
    bit ld, fi, fd, fe, si, sd, se, sm;
    ld = ex_mem_read && (ex_rd_addr != 0) &&
         ((id_rs1_read && id_rs1_addr == ex_rd_addr) ||
          (id_rs2_read && id_rs2_addr == ex_rd_addr));
    {fi, fd, fe, si, sd, se, sm} = '0;
    md_n   = md_busy[k];
    owed_n = owed[k];
    if (rst) begin
      ld = 0; md_n = 0; owed_n = 0;
    end else if (mem_busy) begin
      si = 1; sd = 1; se = 1; sm = 1;
    end else if (md_busy[k]) begin
      if (muldiv_done) md_n = 0;
      else begin si = 1; sd = 1; se = 1; fe = 1; end
    end else if (take_branch) begin
      fi = 1; fd = 1; owed_n = 0;
    end else if (owed[k] > 0) begin
      si = 1; sd = 1; fd = 1; owed_n = owed[k] - 1;
    end else if (muldiv_start) begin
      if (!muldiv_done) begin si = 1; sd = 1; se = 1; fe = 1; md_n = 1; end
    end else if (ld) begin
      si = 1; sd = 1; fd = 1; owed_n = LB[k] - 1;
    end
    e = {fi, fd, fe, si, sd, se, sm, ld};
  endtask

  // Check the current cycle against the model, then advance one clock
  task automatic step(input string tag);
    logic [7:0] e [2];
    bit         mdn [2];
    int         own [2];
    #1;
    for (int k = 0; k < 2; k++) begin
      predict(k, e[k], mdn[k], own[k]);
      check($sformatf("%s.lb%0d.outs", tag, LB[k]), {24'd0, (k == 0) ? obs_lb1 : obs_lb3}, {24'd0, e[k]});
`ifdef HDU_PERF_CNT_EN
      if (!rst) begin
        check($sformatf("%s.lb%0d.pstall", tag, LB[k]), (k == 0) ? ps_lb1 : ps_lb3, m_pstall[k]);
        check($sformatf("%s.lb%0d.pflush", tag, LB[k]), (k == 0) ? pf_lb1 : pf_lb3, m_pflush[k]);
      end
`endif
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      md_busy[k] = mdn[k];
      owed[k]    = own[k];
      if (rst) begin
        m_pstall[k] = '0;
        m_pflush[k] = '0;
      end else begin
        m_pstall[k] = m_pstall[k] + 32'(e[k][4]);
        m_pflush[k] = m_pflush[k] + 32'(e[k][7]);
      end
    end
    #1;
  endtask

  task automatic clr();
    rst = 0; id_rs1_addr = 0; id_rs2_addr = 0; ex_rd_addr = 0;
    id_rs1_read = 0; id_rs2_read = 0; ex_mem_read = 0;
    take_branch = 0; muldiv_start = 0; muldiv_done = 0; mem_busy = 0;
  endtask

  task automatic hazard(input logic [AW-1:0] rd);
    clr();
    ex_mem_read = 1; ex_rd_addr = rd; id_rs1_addr = 5; id_rs1_read = 1;
  endtask

  initial begin
    int st1, st3;
    for (int k = 0; k < 2; k++) begin
      md_busy[k] = 0; owed[k] = 0; m_pstall[k] = '0; m_pflush[k] = '0;
    end
    clr();
    rst = 1;
    muldiv_start = 1; take_branch = 1; mem_busy = 1;  // outputs must stay 0 in reset
    repeat (3) step("reset");
    clr();
    step("idle");

    // Single load-use hazard: 1 bubble for LB=1, 3 bubbles for LB=3
    st1 = 0; st3 = 0;
    hazard(5);
    for (int i = 0; i < 5; i++) begin
      #1;
      st1 += int'(obs_lb1[4]);
      st3 += int'(obs_lb3[4]);
      step("ld_use");
      clr();
    end
    check("ld_use.lb1.bubbles", 32'(st1), 32'd1);
    check("ld_use.lb3.bubbles", 32'(st3), 32'd3);

    // rd = x0 never creates a dependency
    hazard(0); id_rs1_addr = 0;
    step("rd_zero");
    clr();
    step("rd_zero.after");

    // mul/div: start at cycle 0, done at cycle 4
    muldiv_start = 1;
    step("md.c0");
    clr();
    repeat (3) step("md.hold");
    muldiv_done = 1;
    step("md.done");
    clr();
    step("md.after");

    // Branch during the second LOAD_WAIT cycle cancels remaining bubbles
    hazard(5);
    step("br_lw.det");
    clr();
    step("br_lw.wait1");
    take_branch = 1;
    step("br_lw.branch");
    clr();
    repeat (2) step("br_lw.after");

    // mem_busy with a pending branch during LOAD_WAIT
    hazard(5);
    step("mb_lw.det");
    clr();
    mem_busy = 1; take_branch = 1;
    repeat (3) step("mb_lw.busy");
    mem_busy = 0;
    step("mb_lw.branch");
    clr();
    repeat (2) step("mb_lw.after");

    // Reset while mul/div is in flight
    muldiv_start = 1;
    step("rst_md.start");
    clr();
    step("rst_md.hold");
    rst = 1;
    step("rst_md.rst");
    clr();
    repeat (2) step("rst_md.after");

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 63) == 0);
      mem_busy     = ($urandom_range(0, 5) == 0);
      take_branch  = ($urandom_range(0, 7) == 0);
      muldiv_start = ($urandom_range(0, 9) == 0);
      muldiv_done  = ($urandom_range(0, 3) == 0);
      ex_mem_read  = ($urandom_range(0, 2) == 0);
      ex_rd_addr   = AW'($urandom_range(0, 3));
      id_rs1_addr  = AW'($urandom_range(0, 3));
      id_rs2_addr  = AW'($urandom_range(0, 3));
      id_rs1_read  = 1'($urandom_range(0, 1));
      id_rs2_read  = 1'($urandom_range(0, 1));
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hdu_ctrl.md
Name: hdu_ctrl

Overview:
- Parametrised, stateful hazard detect unit for the 5-stage core (IF/ID/EX/MEM/WB).
- Detects load-use hazards internally from register addresses and inserts a configurable number of bubbles.
- Handles branch flush, multi-cycle mul/div occupancy of EX, and LSU back-pressure.
- Drives per-stage stall and flush controls to the pipeline registers.

Parameters:
REG_AW, 5, register address width
LOAD_BUBBLES, 1, bubbles inserted per load-use hazard; legal range 1..(2^CNT_W - 1)
CNT_W, 4, width of the bubble counter
PERF_W, 32, width of the performance counters (only used with HDU_PERF_CNT_EN)

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
id_rs1_addr  input  REG_AW  ID-stage rs1
id_rs2_addr  input  REG_AW  ID-stage rs2
id_rs1_read  input  1  ID instruction reads rs1
id_rs2_read  input  1  ID instruction reads rs2
ex_rd_addr  input  REG_AW  EX-stage rd
ex_mem_read  input  1  EX instruction is a load
take_branch  input  1  EX resolved a taken branch/jump
muldiv_start  input  1  EX holds a mul/div op, first cycle
muldiv_done  input  1  mul/div result valid this cycle
mem_busy  input  1  LSU waiting on bus; MEM cannot advance
if_flush  output  1  kill IF->ID register
id_flush  output  1  bubble into ID->EX register
ex_flush  output  1  bubble into EX->MEM register
if_stall  output  1  hold PC and IF->ID
id_stall  output  1  hold ID->EX
ex_stall  output  1  hold EX->MEM
mem_stall  output  1  hold MEM->WB
load_dep  output  1  raw load-use detect (debug)

Behaviour:
- Single clock domain `clk`. Synchronous active-high `rst`: state=RUN, counter=0.
- While rst=1, all outputs are 0 regardless of other inputs.
- Outputs are combinational from state plus current inputs, so stalls and flushes apply in the detecting cycle (zero latency). State updates on the clk rising edge.
- load_dep = ex_mem_read & (ex_rd_addr!=0) & ((id_rs1_read & rs1==rd) | (id_rs2_read & rs2==rd)).
- States: RUN, LOAD_WAIT, MD_BUSY. Priority each cycle: rst > mem_busy > take_branch > muldiv > load_dep.
- mem_busy=1, any state:
  - if_stall=id_stall=ex_stall=mem_stall=1; all flushes 0.
  - State and counter frozen.
  - A coincident take_branch is not acted on; it is acted on when mem_busy drops, because EX is held.
- RUN, take_branch=1: if_flush=id_flush=1; all stalls 0; stay RUN.
- RUN, muldiv_start=1 and muldiv_done=0:
  - if_stall=id_stall=ex_stall=1, ex_flush=1.
  - Next state MD_BUSY.
  - muldiv_start and muldiv_done together: no stall, stay RUN.
- RUN, load_dep=1: if_stall=id_stall=1, id_flush=1.
  - LOAD_BUBBLES=1: stay RUN.
  - Otherwise: next LOAD_WAIT, counter=LOAD_BUBBLES-1.
- LOAD_WAIT:
  - Each cycle: if_stall=id_stall=1, id_flush=1; counter decrements.
  - When counter==1 (this is the last bubble): next state RUN.
  - Total bubbles = LOAD_BUBBLES.
  - take_branch in LOAD_WAIT: branch flush outputs, stalls 0, next RUN, counter cleared.
- MD_BUSY:
  - muldiv_done=0: if_stall=id_stall=ex_stall=1, ex_flush=1.
  - muldiv_done=1: no stall or flush; next RUN.
  - take_branch and load_dep are ignored; EX holds mul/div, so neither can be valid.
- Flush wins over stall for the same register: if_stall is never asserted with if_flush, and id_stall is never asserted with id_flush from a branch.
- mem_stall is asserted only when mem_busy=1.

Optional Feature:
- Macro HDU_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_stall_cnt (PERF_W): counts cycles with if_stall=1.
  - perf_flush_cnt (PERF_W): counts cycles with if_flush=1.
- Both counters clear on rst and wrap at 2^PERF_W.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Test Plan:
- LOAD_BUBBLES=1, ex_mem_read=1, ex_rd=5, id_rs1=5, rs1_read=1 for one cycle -> that cycle if_stall=id_stall=id_flush=1; next cycle (inputs cleared) all 0, state RUN.
- LOAD_BUBBLES=3, same hazard -> exactly 3 consecutive cycles of if_stall/id_flush, then RUN; ex_rd=0 with match -> load_dep=0, no stall.
- muldiv_start at cycle 0, muldiv_done at cycle 4 -> if_stall=id_stall=ex_stall=ex_flush=1 on cycles 0-3; cycle 4 all 0; RUN at cycle 5.
- LOAD_BUBBLES=3, take_branch in 2nd LOAD_WAIT cycle -> if_flush=id_flush=1, if_stall=0 that cycle; next cycle state RUN with no further stall.
- mem_busy for 3 cycles during LOAD_WAIT with take_branch=1 -> all four stalls=1, flushes=0, counter frozen; after mem_busy drops, branch flush occurs.
- rst asserted in MD_BUSY -> next cycle state RUN, all outputs 0; with HDU_PERF_CNT_EN, both perf counters read 0.
